// File: rtl/dmem_unit.sv
// Data memory with byte-lane stores, sign/zero-extending loads and an MMIO TX FIFO.
// Define DMEM_CYCLE_COUNTER_EN to build the free-running CYCLE counter; otherwise CYCLE reads 0.
module dmem_unit #(
  parameter int DEPTH      = 1024,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wem,
  input  logic [2:0]  rwmm,
  input  logic [31:0] rwam,
  input  logic [31:0] wdm,
  output logic [31:0] rdm,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [2:0] MODE_B  = 3'b000;
  localparam logic [2:0] MODE_H  = 3'b001;
  localparam logic [2:0] MODE_W  = 3'b010;
  localparam logic [2:0] MODE_BU = 3'b100;
  localparam logic [2:0] MODE_HU = 3'b101;

  logic [31:0]   r_mem [DEPTH];
  logic [7:0]    r_fifo [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [3:0]    r_count;
  logic          r_overflow;

  logic [AW-1:0] w_word_idx;
  logic          w_is_mmio;
  logic          w_store_ok;
  logic          w_ram_we;
  logic          w_push;
  logic          w_pop;
  logic          w_push_ok;
  logic          w_full;
  logic          w_empty;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [31:0]   w_cycle;
  logic [31:0]   w_status;
  logic [31:0]   w_word;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic          w_unused;

  assign w_word_idx = rwam[AW+1:2];
  assign w_is_mmio  = rwam[31];
  assign w_unused   = ^rwam;

  // Only the three RV32I store widths write anything; other encodings are inert.
  assign w_store_ok = wem && (rwmm == MODE_B || rwmm == MODE_H || rwmm == MODE_W);
  assign w_ram_we   = w_store_ok && !w_is_mmio;
  assign w_push     = w_store_ok && w_is_mmio && (rwam[3:2] == 2'b00);

  always_comb begin
    w_be    = 4'b0000;
    w_wdata = wdm;
    case (rwmm)
      MODE_B: begin
        w_be    = 4'b0001 << rwam[1:0];
        w_wdata = {4{wdm[7:0]}};
      end
      MODE_H: begin
        w_be    = rwam[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{wdm[15:0]}};
      end
      MODE_W:  w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  // RAM is not reset; stores presented during reset are simply not committed.
  always_ff @(posedge clk) begin
    if (!reset && w_ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_word_idx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  assign w_full    = (r_count == 4'(FIFO_DEPTH));
  assign w_empty   = (r_count == 4'd0);
  assign tx_valid  = !w_empty;
  assign tx_data   = r_fifo[r_rd_ptr];
  assign w_pop     = tx_valid && tx_ready;
  // A same-cycle pop frees a slot, so a push into a full FIFO still lands.
  assign w_push_ok = w_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (!reset && w_push_ok) r_fifo[r_wr_ptr] <= wdm[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= 4'd0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 4'd1;
        2'b01:   r_count <= r_count - 4'd1;
        default: r_count <= r_count;
      endcase
      if (w_push && !w_push_ok) r_overflow <= 1'b1;
    end
  end

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [31:0] r_cycle;
  always_ff @(posedge clk) begin
    if (reset) r_cycle <= 32'd0;
    else       r_cycle <= r_cycle + 32'd1;
  end
  assign w_cycle = r_cycle;
`else
  assign w_cycle = 32'd0;
`endif

  assign w_status = {24'd0, r_count, 1'b0, r_overflow, w_empty, w_full};

  always_comb begin
    w_word = r_mem[w_word_idx];
    if (w_is_mmio) begin
      case (rwam[3:2])
        2'b01:   w_word = w_status;
        2'b10:   w_word = w_cycle;
        default: w_word = 32'd0;
      endcase
    end
  end

  assign w_byte = w_word[{rwam[1:0], 3'b000} +: 8];
  assign w_half = rwam[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    case (rwmm)
      MODE_B:  rdm = {{24{w_byte[7]}}, w_byte};
      MODE_H:  rdm = {{16{w_half[15]}}, w_half};
      MODE_W:  rdm = w_word;
      MODE_BU: rdm = {24'd0, w_byte};
      MODE_HU: rdm = {16'd0, w_half};
      default: rdm = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_dmem_unit.sv
// Directed self-checking bench for dmem_unit: RAM loads/stores, MMIO TX FIFO, reset, CYCLE.
module tb_dmem_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        wem;
  logic [2:0]  rwmm;
  logic [31:0] rwam;
  logic [31:0] wdm;
  logic [31:0] rdm;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] A_TX   = 32'h8000_0000;
  localparam logic [31:0] A_STAT = 32'h8000_0004;
  localparam logic [31:0] A_CYC  = 32'h8000_0008;
  localparam logic [31:0] A_RSV  = 32'h8000_000C;

  dmem_unit #(.DEPTH(1024), .FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .wem      (wem),
    .rwmm     (rwmm),
    .rwam     (rwam),
    .wdm      (wdm),
    .rdm      (rdm),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  always #5 clk = ~clk;

  task automatic do_store(input logic [2:0] m, input logic [31:0] a, input logic [31:0] d);
    wem  = 1'b1;
    rwmm = m;
    rwam = a;
    wdm  = d;
    @(posedge clk);
    #1;
    wem  = 1'b0;
  endtask

  task automatic set_load(input logic [2:0] m, input logic [31:0] a);
    wem  = 1'b0;
    rwmm = m;
    rwam = a;
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    pulse_reset();
    set_load(3'b010, A_STAT);
    checks++;
    if (rdm !== 32'h0000_0002) begin
      failures++;
      $display("FAIL reset_status got=%h exp=%h", rdm, 32'h2);
    end
    checks++;
    if (tx_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_tx_valid got=%b exp=0", tx_valid);
    end
    $display("test_reset done");
  endtask

  task automatic test_loads();
    logic [2:0]  modes [6] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [31:0] addrs [6] = '{32'h10, 32'h13, 32'h13, 32'h12, 32'h12, 32'h10};
    logic [31:0] exps  [6] = '{32'h0000_005D, 32'hFFFF_FF8A, 32'h0000_008A,
                               32'hFFFF_8A7B, 32'h0000_8A7B, 32'h8A7B_6C5D};
    do_store(3'b010, 32'h10, 32'h8A7B_6C5D);
    for (int i = 0; i < 6; i++) begin
      set_load(modes[i], addrs[i]);
      checks++;
      if (rdm !== exps[i]) begin
        failures++;
        $display("FAIL load_%0d mode=%b addr=%h got=%h exp=%h", i, modes[i], addrs[i], rdm, exps[i]);
      end
    end
    // LH at odd address ignores rwam[0]
    set_load(3'b001, 32'h11);
    checks++;
    if (rdm !== 32'h0000_6C5D) begin
      failures++;
      $display("FAIL load_lh_odd got=%h exp=%h", rdm, 32'h0000_6C5D);
    end
    $display("test_loads done");
  endtask

  task automatic test_partial_store();
    do_store(3'b010, 32'h20, 32'h0000_0000);
    do_store(3'b000, 32'h21, 32'h0000_00FF);
    do_store(3'b001, 32'h22, 32'h0000_1234);
    set_load(3'b010, 32'h20);
    checks++;
    if (rdm !== 32'h1234_FF00) begin
      failures++;
      $display("FAIL partial_lw got=%h exp=%h", rdm, 32'h1234_FF00);
    end
    do_store(3'b011, 32'h20, 32'hDEAD_BEEF);
    set_load(3'b010, 32'h20);
    checks++;
    if (rdm !== 32'h1234_FF00) begin
      failures++;
      $display("FAIL invalid_store got=%h exp=%h", rdm, 32'h1234_FF00);
    end
    set_load(3'b011, 32'h20);
    checks++;
    if (rdm !== 32'h0) begin
      failures++;
      $display("FAIL invalid_load got=%h exp=0", rdm);
    end
    set_load(3'b010, 32'h0000_1020);
    checks++;
    if (rdm !== 32'h1234_FF00) begin
      failures++;
      $display("FAIL alias_lw got=%h exp=%h", rdm, 32'h1234_FF00);
    end
    $display("test_partial_store done");
  endtask

  task automatic test_fifo_overflow();
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) do_store(3'b000, A_TX, 32'h41 + i);
    set_load(3'b010, A_STAT);
    checks++;
    if (rdm !== 32'h0000_0045) begin
      failures++;
      $display("FAIL ovf_status got=%h exp=%h", rdm, 32'h45);
    end
    set_load(3'b010, A_TX);
    checks++;
    if (rdm !== 32'h0) begin
      failures++;
      $display("FAIL txdata_read got=%h exp=0", rdm);
    end
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'(8'h41 + i)) begin
        failures++;
        $display("FAIL drain_%0d valid=%b data=%h exp=%h", i, tx_valid, tx_data, 8'(8'h41 + i));
      end
      @(posedge clk);
      #1;
    end
    tx_ready = 1'b0;
    set_load(3'b010, A_STAT);
    checks++;
    if (rdm !== 32'h0000_0006) begin
      failures++;
      $display("FAIL drained_status got=%h exp=%h", rdm, 32'h6);
    end
    $display("test_fifo_overflow done");
  endtask

  task automatic test_back_to_back();
    pulse_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) do_store(3'b010, A_TX, 32'h41 + i);
    set_load(3'b010, A_STAT);
    checks++;
    if (rdm !== 32'h0000_0041) begin
      failures++;
      $display("FAIL full_status got=%h exp=%h", rdm, 32'h41);
    end
    tx_ready = 1'b1;
    do_store(3'b000, A_TX, 32'h55);
    tx_ready = 1'b0;
    set_load(3'b010, A_STAT);
    checks++;
    if (rdm !== 32'h0000_0041) begin
      failures++;
      $display("FAIL pushpop_status got=%h exp=%h", rdm, 32'h41);
    end
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] exp_b;
      exp_b = (i == 3) ? 8'h55 : 8'(8'h42 + i);
      #1;
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp_b) begin
        failures++;
        $display("FAIL pushpop_drain_%0d valid=%b data=%h exp=%h", i, tx_valid, tx_data, exp_b);
      end
      @(posedge clk);
      #1;
    end
    tx_ready = 1'b0;
    do_store(3'b010, A_STAT, 32'hFFFF_FFFF);
    do_store(3'b010, A_RSV, 32'hFFFF_FFFF);
    set_load(3'b010, A_STAT);
    checks++;
    if (rdm !== 32'h0000_0002) begin
      failures++;
      $display("FAIL ro_status got=%h exp=%h", rdm, 32'h2);
    end
    set_load(3'b010, A_RSV);
    checks++;
    if (rdm !== 32'h0) begin
      failures++;
      $display("FAIL rsv_read got=%h exp=0", rdm);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_flush();
    tx_ready = 1'b0;
    do_store(3'b010, 32'h30, 32'h1111_1111);
    do_store(3'b000, A_TX, 32'h61);
    do_store(3'b000, A_TX, 32'h62);
    reset = 1'b1;
    do_store(3'b010, 32'h30, 32'h2222_2222);
    reset = 1'b1;
    do_store(3'b000, A_TX, 32'h63);
    reset = 1'b0;
    #1;
    checks++;
    if (tx_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_tx_valid got=%b exp=0", tx_valid);
    end
    set_load(3'b010, A_STAT);
    checks++;
    if (rdm !== 32'h0000_0002) begin
      failures++;
      $display("FAIL flush_status got=%h exp=%h", rdm, 32'h2);
    end
    set_load(3'b010, 32'h30);
    checks++;
    if (rdm !== 32'h1111_1111) begin
      failures++;
      $display("FAIL reset_store_ignored got=%h exp=%h", rdm, 32'h1111_1111);
    end
    $display("test_reset_flush done");
  endtask

  task automatic test_cycle();
    logic [31:0] exp_c;
`ifdef DMEM_CYCLE_COUNTER_EN
    exp_c = 32'd10;
`else
    exp_c = 32'd0;
`endif
    pulse_reset();
    repeat (9) @(posedge clk);
    do_store(3'b010, A_CYC, 32'h0000_1000);
    set_load(3'b010, A_CYC);
    checks++;
    if (rdm !== exp_c) begin
      failures++;
      $display("FAIL cycle got=%h exp=%h", rdm, exp_c);
    end
    $display("test_cycle done");
  endtask

  initial begin
    reset    = 1'b1;
    wem      = 1'b0;
    rwmm     = 3'b010;
    rwam     = 32'h0;
    wdm      = 32'h0;
    tx_ready = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_loads();
    test_partial_store();
    test_fifo_overflow();
    test_back_to_back();
    test_reset_flush();
    test_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_unit.md
DMEM_UNIT -- requirements
Module: dmem_unit

Interface
REQ-001 Parameter DEPTH, default 1024, SHALL set RAM size in 32-bit words (power of two, 4 KiB default).
REQ-002 Parameter FIFO_DEPTH, default 4, SHALL set TX FIFO entries (power of two, 2..8).
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 wem  input  1  store enable from the core MA stage.
REQ-006 rwmm  input  3  access mode; RV32I load/store funct3 encoding.
REQ-007 rwam  input  32  byte address.
REQ-008 wdm  input  32  store data, LSB-aligned.
REQ-009 rdm  output  32  load data, sign/zero-extended.
REQ-010 tx_data  output  8  FIFO head byte.
REQ-011 tx_valid  output  1  FIFO non-empty.
REQ-012 tx_ready  input  1  consumer accepts head when tx_valid && tx_ready.

Function
REQ-013 Address map: rwam[31]=0 SHALL select RAM, word index rwam[log2(DEPTH)+1:2], upper bits ignored (aliasing); rwam[31]=1 SHALL select MMIO, decoded on rwam[3:2] only.
REQ-014 MMIO: 0x8000_0000 TXDATA (store pushes wdm[7:0], read 0); 0x8000_0004 STATUS (read-only: bit0 full, bit1 empty, bit2 overflow, bits[7:4] count, others 0); 0x8000_0008 CYCLE; 0x8000_000C reads 0, stores ignored.
REQ-015 rdm SHALL be combinational from rwmm/rwam and current state (zero read latency, same cycle); reads SHALL have no side effects.
REQ-016 Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; little-endian; byte lane rwam[1:0], halfword lane rwam[1] (rwam[0] ignored), word ignores rwam[1:0]; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-017 rwmm values 011, 110, 111 SHALL read 0 and SHALL suppress any store.
REQ-018 Stores (wem=1): 000 SB, 001 SH, 010 SW SHALL update only the addressed byte lanes at the rising edge; a load of the same address in the next cycle SHALL return the new data.
REQ-019 Any valid-width store to TXDATA SHALL be a push of wdm[7:0].
REQ-020 Pop occurs when tx_valid && tx_ready; tx_data SHALL be the oldest entry; FIFO is in-order with wrap-around pointers.
REQ-021 Push SHALL be accepted if count<FIFO_DEPTH or a pop occurs in the same cycle; simultaneous push+pop SHALL leave count unchanged.
REQ-022 Push when full without same-cycle pop SHALL be dropped and SHALL set the sticky overflow bit.
REQ-023 Pop when empty SHALL not occur (tx_valid=0); count SHALL never underflow.

Reset
REQ-024 On reset: FIFO empty (count 0, pointers 0), tx_valid 0, overflow 0, CYCLE 0; STATUS reads 0x0000_0002.
REQ-025 RAM contents SHALL NOT be reset; a store or push in a reset cycle SHALL be ignored.
REQ-026 Reset mid-operation SHALL discard pending FIFO entries immediately; tx_data is don't-care while tx_valid=0.
REQ-027 Overflow SHALL be cleared only by reset.

Configuration
REQ-028 Macro DMEM_CYCLE_COUNTER_EN defined: CYCLE SHALL be a free-running 32-bit counter, +1 per clock after reset, wrapping 0xFFFF_FFFF->0; stores to it ignored.
REQ-029 Macro undefined: no counter register SHALL be built and CYCLE SHALL read 0.

Verification
REQ-030 SW 0x8A7B_6C5D @0x10, then LB @0x10 -> 0x0000_005D, LB @0x13 -> 0xFFFF_FF8A, LBU @0x13 -> 0x0000_008A, LH @0x12 -> 0xFFFF_8A7B, LHU @0x12 -> 0x0000_8A7B.
REQ-031 SW 0 @0x20, SB 0xFF @0x21, SH 0x1234 @0x22 -> LW @0x20 = 0x1234_FF00; rwmm=011 store @0x20 -> word unchanged.
REQ-032 tx_ready=0, push 0x41..0x45 (5 pushes, FIFO_DEPTH=4) -> STATUS = 0x0000_0045 (count 4, overflow, full); tx_ready=1 -> tx_data 0x41,0x42,0x43,0x44, then STATUS 0x0000_0006.
REQ-033 FIFO full, push 0x55 with tx_ready=1 same cycle -> 0x41 popped, 0x55 accepted, count stays 4, overflow stays 0.
REQ-034 Macro defined: reset deasserted for 10 cycles -> LW 0x8000_0008 = 10; macro undefined -> 0; reset asserted with 2 FIFO entries -> next cycle tx_valid=0, STATUS 0x0000_0002.
